membus_arbiter: RTL and testbench
=================================

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the maximum consecutive data-side grants made while fetch is waiting; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 i_membus  Membus.slave  addr XLEN, wdata MEMBUS_DATA_WIDTH, wmask MEMBUS_DATA_WIDTH/8  SHALL be the instruction-fetch requester port.
REQ-005 d_membus  Membus.slave  same widths  SHALL be the load/store requester port.
REQ-006 membus  Membus.master  same widths  SHALL be the single downstream port to mmio_controller.

Function
REQ-007 Owner register SHALL take one of {NONE, IBUS, DBUS}; outstanding = (owner != NONE); at most one request outstanding.
REQ-008 can_issue SHALL equal !outstanding || membus.rvalid, so a new request can issue in the same cycle as the previous response.
REQ-009 Selection: if lock set, select lock_id; else if exactly one requester is valid, select it; else if both valid, select DBUS unless starve_cnt == STARVE_LIMIT, then select IBUS.
REQ-010 membus.valid SHALL equal can_issue && selected.valid.
REQ-011 membus addr/wen/wdata/wmask SHALL pass through unmodified from the selected port; they are 0 when membus.valid = 0.
REQ-012 selected.ready SHALL equal can_issue && membus.ready; the non-selected ready SHALL be 0.
REQ-013 Accept = membus.valid && membus.ready; on accept, owner <= selected and lock <= 0.
REQ-014 If membus.valid && !membus.ready, lock <= 1 and lock_id <= selected; the grant SHALL NOT change until accept, even if a higher-priority requester raises valid.
REQ-015 On membus.rvalid with no same-cycle accept, owner <= NONE.
REQ-016 Response routing: owner port rvalid/rdata = membus.rvalid/membus.rdata; the other port rvalid = 0, rdata = 0; zero added latency.
REQ-017 membus.rvalid while owner == NONE SHALL be dropped, not forwarded to either port.
REQ-018 starve_cnt (4 bits) SHALL update as follows:
- DBUS accept while i_membus.valid: cnt <= min(cnt+1, STARVE_LIMIT);
- IBUS accept: cnt <= 0;
- any cycle with i_membus.valid = 0: cnt <= 0.
REQ-019 Simultaneous response to one port and new grant to the other SHALL both occur in that cycle, each port seeing only its own signals.

Reset
REQ-020 While rst = 0: owner <= NONE, lock <= 0, lock_id <= IBUS, starve_cnt <= 0.
REQ-021 While rst = 0: membus.valid, i/d ready and i/d rvalid SHALL be forced to 0.
REQ-022 Reset during an outstanding request SHALL abandon it; a late membus.rvalid after reset release is dropped per REQ-017.

Structure
REQ-023 The owner enum (ArbOwner: NONE, IBUS, DBUS) SHALL live in package eei alongside XLEN and MEMBUS_DATA_WIDTH.
REQ-024 Single flat module, no sub-module: one always_ff for state, one always_comb for muxing and routing; estimated 150-250 lines.

Verification
REQ-025 Only i valid, addr 0x8000_0000, membus.ready = 1, rvalid next cycle with rdata 0x13 -> i.rvalid = 1 with rdata 0x13 one cycle after accept; d.rvalid stays 0.
REQ-026 i and d valid in the same cycle (d addr 0x8000_1000) -> d accepted first; i accepted in the cycle d.rvalid rises; no idle cycle on membus.
REQ-027 STARVE_LIMIT = 4, d valid continuously, i valid -> exactly 4 d grants, then an i grant; starve_cnt returns to 0.
REQ-028 i valid, membus.ready = 0 for 3 cycles, d raises valid in cycle 2 -> membus.addr holds i addr throughout; i accepted on the ready cycle; d granted next.
REQ-029 Outstanding d request, rst pulsed low 1 cycle, rvalid arrives after release -> neither port sees rvalid; owner NONE; next i request accepted normally.

Source files
------------

// File: rtl/eei_pkg.sv
// Shared environment constants and the arbiter owner encoding.
package eei;

    localparam int XLEN              = 32;
    localparam int MEMBUS_DATA_WIDTH = 32;

    // Which requester currently has a request in flight downstream.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } ArbOwner;

endpackage

// File: rtl/membus_if.sv
// Request/response memory bus used between the cores, the arbiter and mmio_controller.
interface Membus;

    logic                                 valid;
    logic                                 ready;
    logic [eei::XLEN-1:0]                 addr;
    logic                                 wen;
    logic [eei::MEMBUS_DATA_WIDTH-1:0]    wdata;
    logic [eei::MEMBUS_DATA_WIDTH/8-1:0]  wmask;
    logic                                 rvalid;
    logic [eei::MEMBUS_DATA_WIDTH-1:0]    rdata;

    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/membus_arbiter.sv
// Two-to-one membus arbiter: instruction fetch and load/store share one downstream port.
// One request may be outstanding; a new request can issue in the cycle its predecessor's
// response returns. Data side wins ties, bounded by STARVE_LIMIT consecutive grants.
module membus_arbiter
    import eei::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst,
    Membus.slave   i_membus,
    Membus.slave   d_membus,
    Membus.master  membus
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    ArbOwner    owner_q, owner_d;
    logic       lock_q, lock_d;
    ArbOwner    lock_id_q, lock_id_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    logic    outstanding;
    logic    can_issue;
    ArbOwner sel;
    logic    sel_valid;
    logic    m_valid;
    logic    accept;

    // Request selection, request/response muxing and next-state computation.
    always_comb begin
        outstanding = (owner_q != NONE);
        can_issue   = !outstanding || membus.rvalid;

        // A stalled request holds the grant until it is accepted.
        if (lock_q) begin
            sel = lock_id_q;
        end else if (i_membus.valid && d_membus.valid) begin
            sel = (starve_cnt_q == Limit) ? IBUS : DBUS;
        end else if (d_membus.valid) begin
            sel = DBUS;
        end else begin
            sel = IBUS;
        end

        sel_valid = (sel == DBUS) ? d_membus.valid : i_membus.valid;
        m_valid   = rst && can_issue && sel_valid;
        accept    = m_valid && membus.ready;

        // Downstream request: pass-through from the selected port, zeroed when idle.
        membus.valid = m_valid;
        membus.addr  = '0;
        membus.wen   = 1'b0;
        membus.wdata = '0;
        membus.wmask = '0;
        if (m_valid) begin
            if (sel == DBUS) begin
                membus.addr  = d_membus.addr;
                membus.wen   = d_membus.wen;
                membus.wdata = d_membus.wdata;
                membus.wmask = d_membus.wmask;
            end else begin
                membus.addr  = i_membus.addr;
                membus.wen   = i_membus.wen;
                membus.wdata = i_membus.wdata;
                membus.wmask = i_membus.wmask;
            end
        end

        i_membus.ready = 1'b0;
        d_membus.ready = 1'b0;
        if (rst && can_issue && membus.ready) begin
            if (sel == DBUS) begin
                d_membus.ready = 1'b1;
            end else begin
                i_membus.ready = 1'b1;
            end
        end

        // Responses go only to the owner; a response with no owner is dropped.
        i_membus.rvalid = 1'b0;
        i_membus.rdata  = '0;
        d_membus.rvalid = 1'b0;
        d_membus.rdata  = '0;
        if (rst) begin
            case (owner_q)
                IBUS: begin
                    i_membus.rvalid = membus.rvalid;
                    i_membus.rdata  = membus.rdata;
                end
                DBUS: begin
                    d_membus.rvalid = membus.rvalid;
                    d_membus.rdata  = membus.rdata;
                end
                default: ;
            endcase
        end

        owner_d      = owner_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        starve_cnt_d = starve_cnt_q;

        if (accept) begin
            owner_d = sel;
            lock_d  = 1'b0;
        end else if (membus.rvalid) begin
            owner_d = NONE;
        end

        if (m_valid && !membus.ready) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (!i_membus.valid) begin
            starve_cnt_d = '0;
        end else if (accept) begin
            if (sel == IBUS) begin
                starve_cnt_d = '0;
            end else begin
                starve_cnt_d = (starve_cnt_q < Limit) ? starve_cnt_q + 4'd1 : Limit;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q      <= NONE;
            lock_q       <= 1'b0;
            lock_id_q    <= IBUS;
            starve_cnt_q <= '0;
        end else begin
            owner_q      <= owner_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter with hand-computed expected values.
module tb_membus_arbiter;

    localparam logic [31:0] IAddr = 32'h8000_0000;
    localparam logic [31:0] DAddr = 32'h8000_1000;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    Membus i_bus ();
    Membus d_bus ();
    Membus m_bus ();

    membus_arbiter #(
        .STARVE_LIMIT(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_membus(i_bus),
        .d_membus(d_bus),
        .membus  (m_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_i(input logic v, input logic [31:0] a);
        i_bus.valid = v;
        i_bus.addr  = a;
        i_bus.wen   = 1'b0;
        i_bus.wdata = '0;
        i_bus.wmask = '0;
    endtask

    task automatic drive_d(input logic v, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [3:0] wm);
        d_bus.valid = v;
        d_bus.addr  = a;
        d_bus.wen   = we;
        d_bus.wdata = wd;
        d_bus.wmask = wm;
    endtask

    task automatic drive_m(input logic rdy, input logic rv, input logic [31:0] rd);
        m_bus.ready  = rdy;
        m_bus.rvalid = rv;
        m_bus.rdata  = rd;
    endtask

    // Inputs change just after a falling edge; checks run 1 time unit later.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    logic [31:0] exp_addr [6];
    logic        exp_is_d [6];

    initial begin
        n_total = 0;
        n_bad   = 0;
        exp_addr = '{DAddr, DAddr, DAddr, DAddr, IAddr, DAddr};
        exp_is_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset forces outputs low even with active inputs.
        rst = 1'b0;
        drive_i(1'b1, IAddr);
        drive_d(1'b0, '0, 1'b0, '0, '0);
        drive_m(1'b1, 1'b1, 32'h1234);
        next_cyc();
        next_cyc();
        #1;
        chk("rst_mvalid", 64'(m_bus.valid), 64'd0);
        chk("rst_iready", 64'(i_bus.ready), 64'd0);
        chk("rst_irvalid", 64'(i_bus.rvalid), 64'd0);
        chk("rst_drvalid", 64'(d_bus.rvalid), 64'd0);
        chk("rst_owner", 64'(dut.owner_q), 64'(eei::NONE));
        chk("rst_cnt", 64'(dut.starve_cnt_q), 64'd0);

        // Single fetch: accept, then response one cycle later.
        next_cyc();
        rst = 1'b1;
        drive_i(1'b1, IAddr);
        drive_m(1'b1, 1'b0, '0);
        #1;
        chk("f_mvalid", 64'(m_bus.valid), 64'd1);
        chk("f_maddr", 64'(m_bus.addr), 64'(IAddr));
        chk("f_iready", 64'(i_bus.ready), 64'd1);
        chk("f_dready", 64'(d_bus.ready), 64'd0);
        next_cyc();
        drive_i(1'b0, '0);
        drive_m(1'b1, 1'b1, 32'h13);
        #1;
        chk("f_irvalid", 64'(i_bus.rvalid), 64'd1);
        chk("f_irdata", 64'(i_bus.rdata), 64'h13);
        chk("f_drvalid", 64'(d_bus.rvalid), 64'd0);
        chk("f_idle_addr", 64'(m_bus.addr), 64'd0);
        next_cyc();
        drive_m(1'b1, 1'b0, '0);

        // Simultaneous requests: data first, fetch issues on data's response cycle.
        next_cyc();
        drive_i(1'b1, IAddr);
        drive_d(1'b1, DAddr, 1'b1, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("s_maddr0", 64'(m_bus.addr), 64'(DAddr));
        chk("s_mwen", 64'(m_bus.wen), 64'd1);
        chk("s_mwdata", 64'(m_bus.wdata), 64'hDEAD_BEEF);
        chk("s_mwmask", 64'(m_bus.wmask), 64'hF);
        chk("s_dready", 64'(d_bus.ready), 64'd1);
        chk("s_iready0", 64'(i_bus.ready), 64'd0);
        next_cyc();
        drive_d(1'b0, '0, 1'b0, '0, '0);
        drive_m(1'b1, 1'b1, 32'hAA);
        #1;
        chk("s_drvalid", 64'(d_bus.rvalid), 64'd1);
        chk("s_drdata", 64'(d_bus.rdata), 64'hAA);
        chk("s_irvalid0", 64'(i_bus.rvalid), 64'd0);
        chk("s_irdata0", 64'(i_bus.rdata), 64'd0);
        chk("s_mvalid1", 64'(m_bus.valid), 64'd1);
        chk("s_maddr1", 64'(m_bus.addr), 64'(IAddr));
        chk("s_iready1", 64'(i_bus.ready), 64'd1);
        next_cyc();
        drive_i(1'b0, '0);
        drive_m(1'b1, 1'b1, 32'h55);
        #1;
        chk("s_irvalid2", 64'(i_bus.rvalid), 64'd1);
        chk("s_irdata2", 64'(i_bus.rdata), 64'h55);
        chk("s_drvalid2", 64'(d_bus.rvalid), 64'd0);
        next_cyc();
        drive_m(1'b1, 1'b0, '0);

        // Starvation bound: four data grants, then a fetch grant.
        next_cyc();
        drive_i(1'b1, IAddr);
        drive_d(1'b1, DAddr, 1'b0, '0, '0);
        drive_m(1'b1, 1'b1, 32'h77);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("sv_addr%0d", k), 64'(m_bus.addr), 64'(exp_addr[k]));
            chk($sformatf("sv_dready%0d", k), 64'(d_bus.ready), 64'(exp_is_d[k]));
            chk($sformatf("sv_iready%0d", k), 64'(i_bus.ready), 64'(!exp_is_d[k]));
            if (k == 0) begin
                chk("sv_drop_i", 64'(i_bus.rvalid), 64'd0);
                chk("sv_drop_d", 64'(d_bus.rvalid), 64'd0);
            end else begin
                chk($sformatf("sv_drv%0d", k), 64'(d_bus.rvalid), 64'(exp_is_d[k-1]));
                chk($sformatf("sv_irv%0d", k), 64'(i_bus.rvalid), 64'(!exp_is_d[k-1]));
            end
            if (k == 4) chk("sv_cnt_full", 64'(dut.starve_cnt_q), 64'd4);
            if (k == 5) chk("sv_cnt_clr", 64'(dut.starve_cnt_q), 64'd0);
            next_cyc();
        end
        drive_i(1'b0, '0);
        drive_d(1'b0, '0, 1'b0, '0, '0);
        #1;
        chk("sv_last_drv", 64'(d_bus.rvalid), 64'd1);
        next_cyc();
        drive_m(1'b1, 1'b0, '0);
        #1;
        chk("sv_owner_none", 64'(dut.owner_q), 64'(eei::NONE));
        chk("sv_cnt_idle", 64'(dut.starve_cnt_q), 64'd0);

        // Stalled fetch keeps the grant while data raises valid.
        next_cyc();
        drive_i(1'b1, IAddr);
        drive_m(1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) drive_d(1'b1, DAddr, 1'b0, '0, '0);
            #1;
            chk($sformatf("lk_addr%0d", k), 64'(m_bus.addr), 64'(IAddr));
            chk($sformatf("lk_iready%0d", k), 64'(i_bus.ready), 64'd0);
            next_cyc();
        end
        drive_m(1'b1, 1'b0, '0);
        #1;
        chk("lk_acc_addr", 64'(m_bus.addr), 64'(IAddr));
        chk("lk_acc_iready", 64'(i_bus.ready), 64'd1);
        chk("lk_acc_dready", 64'(d_bus.ready), 64'd0);
        next_cyc();
        drive_i(1'b0, '0);
        drive_m(1'b1, 1'b1, 32'h66);
        #1;
        chk("lk_irvalid", 64'(i_bus.rvalid), 64'd1);
        chk("lk_d_addr", 64'(m_bus.addr), 64'(DAddr));
        chk("lk_d_ready", 64'(d_bus.ready), 64'd1);
        next_cyc();
        drive_d(1'b0, '0, 1'b0, '0, '0);
        drive_m(1'b1, 1'b1, 32'h88);
        #1;
        chk("lk_drvalid", 64'(d_bus.rvalid), 64'd1);
        chk("lk_drdata", 64'(d_bus.rdata), 64'h88);
        next_cyc();
        drive_m(1'b1, 1'b0, '0);

        // Reset abandons an outstanding data request; the late response is dropped.
        next_cyc();
        drive_d(1'b1, DAddr, 1'b0, '0, '0);
        #1;
        chk("ra_dready", 64'(d_bus.ready), 64'd1);
        next_cyc();
        drive_d(1'b0, '0, 1'b0, '0, '0);
        rst = 1'b0;
        #1;
        chk("ra_rst_mvalid", 64'(m_bus.valid), 64'd0);
        next_cyc();
        rst = 1'b1;
        drive_m(1'b1, 1'b1, 32'h99);
        #1;
        chk("ra_late_drv", 64'(d_bus.rvalid), 64'd0);
        chk("ra_late_drd", 64'(d_bus.rdata), 64'd0);
        chk("ra_late_irv", 64'(i_bus.rvalid), 64'd0);
        chk("ra_owner", 64'(dut.owner_q), 64'(eei::NONE));
        next_cyc();
        drive_i(1'b1, IAddr);
        drive_m(1'b1, 1'b0, '0);
        #1;
        chk("ra_i_mvalid", 64'(m_bus.valid), 64'd1);
        chk("ra_i_ready", 64'(i_bus.ready), 64'd1);
        next_cyc();
        drive_i(1'b0, '0);
        drive_m(1'b1, 1'b1, 32'h42);
        #1;
        chk("ra_i_rvalid", 64'(i_bus.rvalid), 64'd1);
        chk("ra_i_rdata", 64'(i_bus.rdata), 64'h42);
        chk("ra_d_rvalid", 64'(d_bus.rvalid), 64'd0);
        next_cyc();
        drive_m(1'b0, 1'b0, '0);
        next_cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
